stopwatch_control: RTL and testbench
====================================

Name: stopwatch_control

Overview:
Front-end control stage for the stopwatch datapath. It takes raw mechanical push-button inputs (start, stop, clear) and synchronises and debounces each one. It runs a small run/pause/idle state machine and drives clean, single-clock control signals into the stopwatch counter and display path. It also provides a lap/freeze function: the display holds while the counter keeps running.

Parameters:
DB_CYCLES, 2000000, consecutive clk_i cycles a synchronised button level must differ from the accepted level before it is accepted (20 ms at 100 MHz); must be >= 2
SYNC_STAGES, 2, flip-flop stages in each button's metastability synchroniser; must be >= 2

Ports:
clk_i  input  1  system clock; the only clock
rst_i  input  1  synchronous, active-high reset
start_btn_i  input  1  raw start/lap button, asynchronous, active-high
stop_btn_i  input  1  raw stop button, asynchronous, active-high
clear_btn_i  input  1  raw clear button, asynchronous, active-high
run_o  output  1  count enable to stopwatch; high only in RUNNING
clear_o  output  1  one-cycle pulse that zeroes the stopwatch time registers
freeze_o  output  1  display hold (lap); the counter continues while high
state_o  output  2  FSM state: 00 IDLE, 01 RUNNING, 10 PAUSED (11 never driven)

Behaviour:
- One clock domain (clk_i); reset is synchronous, active-high, sampled on the rising edge.
- Reset values:
  - FSM = IDLE; run_o = 0, clear_o = 0, freeze_o = 0, state_o = 00.
  - All synchroniser flops, accepted levels and debounce counters = 0.
  - All press pulses = 0.
  - Reset asserted mid-operation aborts everything in the same edge, including any debounce in progress.
- Per-button front end (three identical instances):
  - SYNC_STAGES-deep flop chain produces the synchronised level s.
  - Accepted level db.
  - Counter cnt, width $clog2(DB_CYCLES).
- Per-button debounce rules:
  - If s == db: cnt <= 0.
  - Else if cnt == DB_CYCLES-1: db <= s, cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any bounce back to db before DB_CYCLES consecutive differing cycles restarts the count from 0.
- Press pulse: press_r <= 1 on the edge where db transitions 0->1; otherwise 0. Width is exactly one cycle. Release (1->0) generates no pulse.
- Latency: a clean press (raw high, already stable before edge 1) gives press_r high after edge SYNC_STAGES+DB_CYCLES. The FSM reacts on the next edge, so run_o/state_o change after edge SYNC_STAGES+DB_CYCLES+1.
- Holding a button indefinitely yields exactly one pulse.
- FSM (registered; outputs are decoded from registered state/flags, no combinational path from inputs):
  - IDLE:
    - start -> RUNNING, freeze_o = 0.
    - clear -> stay IDLE, clear_o pulse.
    - stop -> ignored.
  - RUNNING:
    - stop -> PAUSED, freeze_o <= 0.
    - start -> stay RUNNING, freeze_o toggles (lap).
    - clear -> ignored (must stop first).
  - PAUSED:
    - start -> RUNNING, freeze_o = 0.
    - clear -> IDLE, clear_o pulse.
    - stop -> ignored.
- Simultaneous press pulses in one cycle: priority clear > stop > start. Only the highest-priority press that is legal in the current state acts; the rest are discarded, not queued.
  - Example: clear+start in RUNNING -> clear is illegal, so the next priority (start) is evaluated and the lap toggle occurs.
  - Example: stop+start in RUNNING -> PAUSED.
- clear_o: asserted for exactly one cycle, on the same edge as the accepting state update; never two consecutive cycles.
- run_o = (state == RUNNING); state_o mirrors the state encoding.
- freeze_o is 0 whenever state != RUNNING.

Test Plan:
- Clean start (DB_CYCLES=4, SYNC_STAGES=2): from reset, hold start_btn_i high from before edge 1 -> run_o=1 and state_o=01 after edge 7, not before; clear_o stays 0.
- Bounce rejection: start_btn_i high 3 cycles, low 1, high 3, low -> no press; run_o stays 0. Then held 10 cycles -> exactly one transition to RUNNING.
- Run/pause/clear: start -> stop (run_o falls, state_o=10) -> clear -> clear_o high exactly 1 cycle, state_o=00. A clear pressed while state_o=01 -> no clear_o, state unchanged.
- Lap: in RUNNING press start twice -> freeze_o 0->1->0, run_o stays 1. Press start once then stop -> freeze_o=0 in PAUSED.
- Simultaneous: drive stop and start identically in RUNNING -> state_o=10, freeze_o unchanged 0. Drive clear and start identically in PAUSED -> state_o=00, single clear_o pulse.
- Reset mid-debounce: start held 3 cycles, rst_i for 1 cycle, start keeps held -> run_o rises only 7 edges after rst_i deasserts. Outputs are all 0 on the edge after rst_i.

Source files
------------

// File: rtl/stopwatch_control.sv
// Stopwatch front end: synchronise and debounce three buttons, then run an idle/run/pause FSM with lap freeze.
// Press-to-output latency is SYNC_STAGES+DB_CYCLES+1 clocks; there is no backpressure, and discarded presses are never queued.
module stopwatch_control #(
    parameter int DB_CYCLES   = 2000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_btn_i,
    input  logic       stop_btn_i,
    input  logic       clear_btn_i,
    output logic       run_o,
    output logic       clear_o,
    output logic       freeze_o,
    output logic [1:0] state_o
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    // Button index: 0 = start, 1 = stop, 2 = clear.
    logic [2:0] w_raw;
    logic [2:0] w_press;

    assign w_raw = {clear_btn_i, stop_btn_i, start_btn_i};

    for (genvar g = 0; g < 3; g++) begin : g_btn
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   r_db;
        logic [CW-1:0]          r_cnt;
        logic                   r_press;
        logic                   w_s;

        assign w_s        = r_sync[SYNC_STAGES-1];
        assign w_press[g] = r_press;

        // A level is accepted only after DB_CYCLES consecutive differing samples.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_sync  <= '0;
                r_db    <= 1'b0;
                r_cnt   <= '0;
                r_press <= 1'b0;
            end else begin
                r_sync  <= {r_sync[SYNC_STAGES-2:0], w_raw[g]};
                r_press <= 1'b0;
                if (w_s == r_db) begin
                    r_cnt <= '0;
                end else if (r_cnt == CNT_MAX) begin
                    r_db    <= w_s;
                    r_cnt   <= '0;
                    r_press <= w_s;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    state_t r_state, w_state_nxt;
    logic   r_freeze, w_freeze_nxt;
    logic   r_clear, w_clear_nxt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_freeze <= 1'b0;
            r_clear  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_freeze <= w_freeze_nxt;
            r_clear  <= w_clear_nxt;
        end
    end

    // Priority clear > stop > start, skipping any press that is illegal in the current state.
    always_comb begin
        w_state_nxt  = r_state;
        w_freeze_nxt = r_freeze;
        w_clear_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_press[2]) begin
                    w_clear_nxt = 1'b1;
                end else if (w_press[0]) begin
                    w_state_nxt  = ST_RUN;
                    w_freeze_nxt = 1'b0;
                end
            end
            ST_RUN: begin
                if (w_press[1]) begin
                    w_state_nxt  = ST_PAUSE;
                    w_freeze_nxt = 1'b0;
                end else if (w_press[0]) begin
                    w_freeze_nxt = ~r_freeze;
                end
            end
            ST_PAUSE: begin
                if (w_press[2]) begin
                    w_state_nxt  = ST_IDLE;
                    w_clear_nxt  = 1'b1;
                    w_freeze_nxt = 1'b0;
                end else if (w_press[0]) begin
                    w_state_nxt  = ST_RUN;
                    w_freeze_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_freeze_nxt = 1'b0;
            end
        endcase
    end

    assign run_o    = (r_state == ST_RUN);
    assign clear_o  = r_clear;
    assign freeze_o = r_freeze;
    assign state_o  = r_state;

endmodule

// File: tb/tb_stopwatch_control.sv
// Randomised and directed bench for stopwatch_control; a reference model predicts the outputs for every clock.
module tb_stopwatch_control;

    localparam int DB = 4;
    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic       start_btn_i = 1'b0;
    logic       stop_btn_i = 1'b0;
    logic       clear_btn_i = 1'b0;
    logic       run_o, clear_o, freeze_o;
    logic [1:0] state_o;

    stopwatch_control #(.DB_CYCLES(DB), .SYNC_STAGES(SS)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_btn_i (start_btn_i),
        .stop_btn_i  (stop_btn_i),
        .clear_btn_i (clear_btn_i),
        .run_o       (run_o),
        .clear_o     (clear_o),
        .freeze_o    (freeze_o),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc_no = 0;
    logic [4:0] exp_q[$];

    // Reference model: the history of raw samples, the accepted level per button,
    // and the number of consecutive cycles the synchronised level has disagreed with it.
    bit m_hist[3][SS];
    bit m_db[3];
    int m_diff[3];
    bit m_press[3];
    int m_state;
    bit m_frz;
    bit m_clr;

    task automatic model_step(input bit r, input bit raw0, input bit raw1, input bit raw2);
        bit raw[3];
        bit s;
        bit np;
        bit do_clear, do_stop, do_start;
        raw[0] = raw0; raw[1] = raw1; raw[2] = raw2;
        if (r) begin
            for (int b = 0; b < 3; b++) begin
                for (int i = 0; i < SS; i++) m_hist[b][i] = 1'b0;
                m_db[b] = 1'b0; m_diff[b] = 0; m_press[b] = 1'b0;
            end
            m_state = 0; m_frz = 1'b0; m_clr = 1'b0;
        end else begin
            do_clear = m_press[2] && (m_state != 1);
            do_stop  = m_press[1] && (m_state == 1) && !do_clear;
            do_start = m_press[0] && !do_clear && !do_stop;
            m_clr = do_clear;
            if (do_clear) begin
                m_state = 0; m_frz = 1'b0;
            end else if (do_stop) begin
                m_state = 2; m_frz = 1'b0;
            end else if (do_start) begin
                if (m_state == 1) m_frz = !m_frz;
                else begin m_state = 1; m_frz = 1'b0; end
            end
            for (int b = 0; b < 3; b++) begin
                s  = m_hist[b][SS-1];
                np = 1'b0;
                if (s != m_db[b]) begin
                    m_diff[b]++;
                    if (m_diff[b] == DB) begin
                        m_db[b] = s; m_diff[b] = 0; np = s;
                    end
                end else begin
                    m_diff[b] = 0;
                end
                m_press[b] = np;
                for (int i = SS - 1; i > 0; i--) m_hist[b][i] = m_hist[b][i-1];
                m_hist[b][0] = raw[b];
            end
        end
        exp_q.push_back({(m_state == 1), m_clr, m_frz, 2'(m_state)});
    endtask

    task automatic cyc(input bit r, input bit st, input bit sp, input bit cl);
        @(negedge clk);
        rst_i = r; start_btn_i = st; stop_btn_i = sp; clear_btn_i = cl;
        model_step(r, st, sp, cl);
    endtask

    task automatic hold(input int n, input bit st, input bit sp, input bit cl);
        for (int i = 0; i < n; i++) cyc(1'b0, st, sp, cl);
    endtask

    task automatic press(input bit st, input bit sp, input bit cl);
        hold(8, st, sp, cl);
        hold(8, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: one expected output vector per clock edge, compared just after the edge.
    initial begin
        logic [4:0] e, got;
        forever begin
            @(posedge clk);
            #1;
            cyc_no++;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {run_o, clear_o, freeze_o, state_o};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL outputs cycle %0d: run/clear/freeze/state got %b/%b/%b/%b expected %b/%b/%b/%b",
                             cyc_no, got[4], got[3], got[2], got[1:0], e[4], e[3], e[2], e[1:0]);
                end
            end
        end
    end

    initial begin
        bit lv[3];
        bit tie;
        cyc(1'b1, 0, 0, 0);
        cyc(1'b1, 0, 0, 0);
        // Clean start, then release
        hold(10, 1, 0, 0);
        hold(8, 0, 0, 0);
        // Bounce rejection from IDLE
        cyc(1'b1, 0, 0, 0);
        hold(3, 1, 0, 0); hold(1, 0, 0, 0); hold(3, 1, 0, 0); hold(8, 0, 0, 0);
        hold(10, 1, 0, 0); hold(8, 0, 0, 0);
        // Stop, clear, restart, illegal clear while running
        press(0, 1, 0);
        press(0, 0, 1);
        press(1, 0, 0);
        press(0, 0, 1);
        // Lap twice, lap then stop
        press(1, 0, 0);
        press(1, 0, 0);
        press(1, 0, 0);
        press(0, 1, 0);
        // Simultaneous presses
        press(1, 0, 0);
        press(1, 1, 0);
        press(1, 0, 1);
        // Reset in the middle of a debounce
        hold(3, 1, 0, 0);
        cyc(1'b1, 1, 0, 0);
        hold(10, 1, 0, 0);
        hold(8, 0, 0, 0);
        // Random button activity with bounces, ties and occasional resets
        lv[0] = 0; lv[1] = 0; lv[2] = 0; tie = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) tie = !tie;
            for (int b = 0; b < 3; b++)
                if ($urandom_range(0, 9) == 0) lv[b] = !lv[b];
            if (tie) lv[1] = lv[0];
            cyc(($urandom_range(0, 499) == 0), lv[0], lv[1], lv[2]);
        end
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
